cam_capture_ctrl: RTL
=====================

// Module: cam_capture_ctrl
// PURPOSE
//  Sequences single-frame capture from the parallel camera port (8-bit DVP: vsync/href/data, already
//  registered in the IO cells on cam_xclk). Waits for a frame boundary after a software start, packs
//  byte pairs into 16-bit RGB565 pixels, and writes them to scratchpad through a valid/ready port
//  with line-major addresses. Sits between the camera IO registers and the scratchpad write arbiter.
// PARAMETERS
//  H_PIXELS    160  pixels per line kept; later pixels in a line are dropped
//  V_LINES     120  lines per frame kept; later lines are dropped
//  ADDR_WIDTH  15   pixel address width; must satisfy 2**ADDR_WIDTH >= H_PIXELS*V_LINES
// PORTS
//  clk          in   1   camera pixel clock (cam_xclk domain); all logic on the rising edge
//  reset        in   1   asynchronous, active-high
//  cam_vsync    in   1   frame sync; high = vertical blanking
//  cam_href     in   1   line valid; high = data bytes valid
//  cam_dat      in   8   pixel byte
//  start        in   1   1-cycle pulse: arm capture of next frame (ignored unless IDLE)
//  abort        in   1   1-cycle pulse: return to IDLE from any state; no frame_done pulse
//  busy         out  1   high in every state except IDLE
//  frame_done   out  1   1-cycle pulse on completion of a captured frame
//  overrun      out  1   sticky: >=1 pixel lost to backpressure; cleared by accepted start
//  wr_valid     out  1   pixel write request
//  wr_ready     in   1   scratchpad accepts the write
//  wr_addr      out  ADDR_WIDTH  pixel address = line*H_PIXELS + column
//  wr_data      out  16  {first byte, second byte}
// BEHAVIOUR
//  Reset: state IDLE; busy, frame_done, overrun, wr_valid = 0; wr_addr, wr_data = 0; counters = 0.
//  FSM: IDLE -start-> ARM; ARM: wait vsync=1 -> SYNC; SYNC: wait vsync=0 (frame start) -> CAPTURE;
//   CAPTURE: vsync rising edge -> DONE; DONE: 1 cycle, frame_done=1 -> IDLE.
//   ARM ensures capture never begins mid-frame even when start arrives while vsync=0.
//  In CAPTURE, with href=1: byte phase toggles each cycle; phase 0 latches high byte, phase 1 forms
//   pixel. href falling edge: line++, column=0, phase=0; trailing odd byte discarded.
//  Pixel kept only if column<H_PIXELS and line<V_LINES; column advances for every formed pixel.
//  Output: pixel registered into wr_data/wr_addr with wr_valid=1 on the cycle after phase-1 byte
//   (latency 1). wr_valid/addr/data held stable until wr_valid&&wr_ready.
//  Collision: new pixel ready while wr_valid&&!wr_ready -> new pixel dropped, overrun<=1, held
//   request unchanged. Simultaneous handshake and new pixel -> new pixel loads, no overrun.
//  Outstanding write at vsync rise completes normally; DONE waits for it (DONE persists until
//   wr_valid=0), frame_done asserts in the cycle the last write is accepted or later.
//  abort or start in same cycle: abort wins. abort drops any pending write (wr_valid<=0).
//  start accepted: overrun, line, column, phase cleared.
//  Counter widths sized to H_PIXELS/V_LINES with $clog2; counters saturate, never wrap.
// CONFIGURATION
//  CAM_DOWNSCALE_EN defined: 2x subsample - only even columns of even lines kept; wr_addr =
//   (line/2)*(H_PIXELS/2) + column/2; limits H_PIXELS/2 x V_LINES/2 kept.
//  Undefined: full-resolution behaviour above; no subsample logic present.
// STRUCTURE
//  cam_capture_pkg: state enum (IDLE, ARM, SYNC, CAPTURE, DONE), RGB565 pixel typedef,
//   column/line counter width constants.
//  Sub-module cam_byte_packer: href edge detection, byte phase, 16-bit pixel assembly and
//   pixel_strobe; FSM, counters, address and write handshake stay in cam_capture_ctrl.
// TESTING
//  Start with vsync=0 mid-frame -> no writes until full vsync high/low cycle; then
//   4x2 frame writes addr 0..7.
//  Line bytes 0x12,0x34,0x56,0x78 with wr_ready=1 -> writes (0,0x1234),(1,0x5678);
//   frame_done one pulse after vsync rise.
//  wr_ready=0 for 3 pixels -> first held at addr 0, next two dropped, overrun=1;
//   next start clears overrun.
//  Line of 161 pixels + odd byte (H_PIXELS=160) -> 160 writes, last addr 159, next line starts at 160.
//  abort mid-line with wr_valid=1 -> wr_valid=0, busy=0 next cycle, no frame_done.
//  CAM_DOWNSCALE_EN, 4x4 frame -> writes only pixels (0,0),(0,2),(2,0),(2,2) at addr 0,1,2,3.

Source files
------------

// File: rtl/cam_capture_pkg.sv
// Shared types and sizing helpers for the DVP single-frame capture block.
// State encoding, RGB565 pixel layout and counter width helpers used by cam_capture_ctrl.
package cam_capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SYNC,
        CAPTURE,
        DONE
    } state_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    localparam int unsigned H_PIXELS_DEF   = 160;
    localparam int unsigned V_LINES_DEF    = 120;
    localparam int unsigned ADDR_WIDTH_DEF = 15;

    // Counters must be able to hold the limit itself so they can saturate there.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return $clog2(limit + 1);
    endfunction

    localparam int unsigned COL_W_DEF  = cnt_width(H_PIXELS_DEF);
    localparam int unsigned LINE_W_DEF = cnt_width(V_LINES_DEF);

endpackage

// File: rtl/cam_byte_packer.sv
// Byte-pair assembler for the 8-bit DVP bus: tracks byte phase while href is high,
// latches the high byte and flags a complete RGB565 pixel plus the end of each line.
module cam_byte_packer
    import cam_capture_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       href,
    input  logic [7:0] dat,
    output logic       pixel_strobe,
    output rgb565_t    pixel,
    output logic       line_end
);

    logic       href_q;
    logic       phase_q;
    logic       phase_d;
    logic [7:0] hi_q;

    // Phase falls back to 0 whenever href drops, which discards a trailing odd byte.
    assign phase_d = en && href && !phase_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            href_q  <= 1'b0;
            phase_q <= 1'b0;
            hi_q    <= '0;
        end else begin
            href_q  <= href;
            phase_q <= clr ? 1'b0 : phase_d;
            if (en && href && !phase_q) begin
                hi_q <= dat;
            end
        end
    end

    // NOTE: strobe and pixel are combinational so the controller registers the pixel
    // on the same edge that samples the second byte, giving one cycle of latency.
    assign pixel_strobe = en && href && phase_q;
    assign pixel        = {hi_q, dat};
    assign line_end     = en && href_q && !href;

endmodule

// File: rtl/cam_capture_ctrl.sv
// Single-frame DVP capture controller: frame-aligned arming, pixel counting, line-major
// addressing and a held valid/ready write port. Optional 2x subsample under CAM_DOWNSCALE_EN.
module cam_capture_ctrl
    import cam_capture_pkg::*;
#(
    parameter int unsigned H_PIXELS   = H_PIXELS_DEF,
    parameter int unsigned V_LINES    = V_LINES_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cam_vsync,
    input  logic                  cam_href,
    input  logic [7:0]            cam_dat,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [15:0]           wr_data
);

    localparam int unsigned COL_W  = cnt_width(H_PIXELS);
    localparam int unsigned LINE_W = cnt_width(V_LINES);
    localparam logic [COL_W-1:0]  H_LIM = COL_W'(H_PIXELS);
    localparam logic [LINE_W-1:0] V_LIM = LINE_W'(V_LINES);

    state_t                  state_q;
    logic                    vsync_q;
    logic [COL_W-1:0]        col_q;
    logic [LINE_W-1:0]       line_q;
    logic                    busy_q;
    logic                    frame_done_q;
    logic                    overrun_q;
    logic                    wr_valid_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    rgb565_t                 wr_data_q;

    logic                    start_acc;
    logic                    pixel_strobe;
    rgb565_t                 pixel;
    logic                    line_end;
    logic                    keep;
    logic                    can_load;
    logic [ADDR_WIDTH-1:0]   pix_addr;
    logic [COL_W-1:0]        col_inc;
    logic [LINE_W-1:0]       line_inc;

    assign start_acc = start && !abort && (state_q == IDLE);
    assign can_load  = !wr_valid_q || wr_ready;
    assign col_inc   = (col_q == H_LIM) ? col_q : col_q + 1'b1;
    assign line_inc  = (line_q == V_LIM) ? line_q : line_q + 1'b1;

`ifdef CAM_DOWNSCALE_EN
    localparam logic [ADDR_WIDTH-1:0] H_HALF = ADDR_WIDTH'(H_PIXELS / 2);
    assign keep     = (col_q < H_LIM) && (line_q < V_LIM) && !col_q[0] && !line_q[0];
    assign pix_addr = ADDR_WIDTH'(line_q >> 1) * H_HALF + ADDR_WIDTH'(col_q >> 1);
`else
    localparam logic [ADDR_WIDTH-1:0] H_MUL = ADDR_WIDTH'(H_PIXELS);
    assign keep     = (col_q < H_LIM) && (line_q < V_LIM);
    assign pix_addr = ADDR_WIDTH'(line_q) * H_MUL + ADDR_WIDTH'(col_q);
`endif

    cam_byte_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clr          (start_acc || abort),
        .en           (state_q == CAPTURE),
        .href         (cam_href),
        .dat          (cam_dat),
        .pixel_strobe (pixel_strobe),
        .pixel        (pixel),
        .line_end     (line_end)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            vsync_q      <= 1'b0;
            col_q        <= '0;
            line_q       <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            vsync_q      <= cam_vsync;
            frame_done_q <= 1'b0;
            // NOTE: the handshake clear comes first; a pixel loaded later in this block
            // overrides it, which is how a simultaneous accept-and-load works.
            if (wr_valid_q && wr_ready) begin
                wr_valid_q <= 1'b0;
            end

            if (abort) begin
                state_q    <= IDLE;
                busy_q     <= 1'b0;
                wr_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q   <= ARM;
                            busy_q    <= 1'b1;
                            overrun_q <= 1'b0;
                            col_q     <= '0;
                            line_q    <= '0;
                        end
                    end
                    ARM: begin
                        if (cam_vsync) state_q <= SYNC;
                    end
                    SYNC: begin
                        if (!cam_vsync) state_q <= CAPTURE;
                    end
                    CAPTURE: begin
                        if (cam_vsync && !vsync_q) state_q <= DONE;
                        if (line_end) begin
                            col_q  <= '0;
                            line_q <= line_inc;
                        end else if (pixel_strobe) begin
                            col_q <= col_inc;
                            if (keep) begin
                                if (can_load) begin
                                    wr_valid_q <= 1'b1;
                                    wr_addr_q  <= pix_addr;
                                    wr_data_q  <= pixel;
                                end else begin
                                    overrun_q <= 1'b1;
                                end
                            end
                        end
                    end
                    DONE: begin
                        // Hold here until the last outstanding write has been accepted.
                        if (can_load) begin
                            state_q      <= IDLE;
                            busy_q       <= 1'b0;
                            frame_done_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;
    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;

endmodule
